// File: rtl/note_pkg.sv
// Shared definitions for the note scheduler.
//   SC_BREAK / SC_EXT : PS/2 Set-2 prefix bytes
//   parse_state_t     : scan-code parser states
//   note_t            : {hit, freq} result of a key lookup
//   note_lookup()     : maps a make/break code to a tone frequency in Hz
package note_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int CODE_W = 8;
  localparam int FREQ_W = 12;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic              hit;
    logic [FREQ_W-1:0] freq;
  } note_t;

  // A miss returns all zeros, so every mapped entry is distinguishable by a
  // non-zero frequency as well as by the hit bit.
  function automatic note_t note_lookup(input logic [CODE_W-1:0] code);
    note_t r;
    r.hit  = 1'b1;
    r.freq = '0;
    case (code)
      8'h1C:   r.freq = 12'd262;
      8'h1B:   r.freq = 12'd294;
      8'h23:   r.freq = 12'd330;
      8'h2B:   r.freq = 12'd349;
      8'h34:   r.freq = 12'd392;
      8'h33:   r.freq = 12'd440;
      8'h3B:   r.freq = 12'd494;
      8'h42:   r.freq = 12'd523;
      default: r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/note_scheduler_key_stack.sv
// Last-note-priority stack of held key codes.
//   clk, rst_n : clock, asynchronous active-low reset (clears count only)
//   ev_vld     : one key event this cycle
//   ev_brk     : 1 = break (remove), 0 = make (push)
//   ev_code    : key code of the event
//   count      : registered number of valid entries
//   nxt_count  : entry count after this cycle's event
//   nxt_top    : newest code after this cycle's event (0 when empty)
// Entry 0 is the oldest. A make of a held code is ignored; a make on a full
// stack drops entry 0; a break removes the matching entry and closes the gap.
module key_stack
  import note_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_vld,
  input  logic              ev_brk,
  input  logic [CODE_W-1:0] ev_code,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  nxt_count,
  output logic [CODE_W-1:0] nxt_top
);

  logic [CODE_W-1:0] ent     [DEPTH];
  logic [CODE_W-1:0] nxt_ent [DEPTH];
  logic              hit;
  logic [CNT_W-1:0]  hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (ent[i] == ev_code)) begin
        hit     = 1'b1;
        hit_idx = CNT_W'(i);
      end
    end
  end

  always_comb begin
    nxt_ent   = ent;
    nxt_count = count;
    if (ev_vld && !ev_brk && !hit) begin
      if (count < CNT_W'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == count) nxt_ent[i] = ev_code;
        end
        nxt_count = count + CNT_W'(1);
      end else begin
        // Full: the oldest key falls off the bottom.
        for (int i = 0; i < DEPTH - 1; i++) nxt_ent[i] = ent[i + 1];
        nxt_ent[DEPTH-1] = ev_code;
      end
    end else if (ev_vld && ev_brk && hit) begin
      // Compact everything above the released key down by one slot.
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CNT_W'(i) >= hit_idx) nxt_ent[i] = ent[i + 1];
      end
      nxt_count = count - CNT_W'(1);
    end
  end

  always_comb begin
    nxt_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) + CNT_W'(1) == nxt_count) nxt_top = nxt_ent[i];
    end
  end

  // ---- stack register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= nxt_count;
  end

  always_ff @(posedge clk) begin
    ent <= nxt_ent;
  end

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: PS/2 Set-2 scan codes in, speaker frequency word out.
//   clk, rst_n  : clock, asynchronous active-low reset
//   scan_code   : received PS/2 byte
//   scan_valid  : one-cycle strobe qualifying scan_code
//   note_freq   : frequency word in Hz, 0 = silent
//   gate        : 1 while a note sounds (held or in release tail)
//   note_change : one-cycle pulse whenever note_freq changes
//   held_count  : number of keys on the stack
// All outputs are registered one cycle after the causing scan_valid.
module note_scheduler
  import note_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TAIL_CYCLES = 0,
  parameter int TAIL_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] scan_code,
  input  logic              scan_valid,
  output logic [FREQ_W-1:0] note_freq,
  output logic              gate,
  output logic              note_change,
  output logic [CNT_W-1:0]  held_count
);

  localparam logic [TAIL_W-1:0] TAIL_C = TAIL_W'(TAIL_CYCLES);

  parse_state_t      pstate, pstate_nxt;
  note_t             key_p0;
  logic              key_hit_p0;
  logic              ev_vld_p0;
  logic              ev_brk_p0;

  logic [CNT_W-1:0]  nxt_count;
  logic [CODE_W-1:0] nxt_top;
  note_t             top_note;

  logic [FREQ_W-1:0] freq_nxt;
  logic              gate_nxt;
  logic [TAIL_W-1:0] tail_cnt_p1, tail_nxt;

  // ---- stage p0: byte decode and parser ----
  assign key_p0     = note_lookup(scan_code);
  assign key_hit_p0 = key_p0.hit & (key_p0.freq != '0);

  always_comb begin
    pstate_nxt = pstate;
    ev_vld_p0  = 1'b0;
    ev_brk_p0  = 1'b0;
    if (scan_valid) begin
      case (pstate)
        IDLE: begin
          if (scan_code == SC_BREAK)    pstate_nxt = BRK;
          else if (scan_code == SC_EXT) pstate_nxt = EXT;
          else                          ev_vld_p0  = key_hit_p0;
        end
        BRK: begin
          ev_vld_p0  = key_hit_p0;
          ev_brk_p0  = 1'b1;
          pstate_nxt = IDLE;
        end
        // Extended keys are not musical; their bytes are swallowed.
        EXT: begin
          if (scan_code == SC_BREAK) pstate_nxt = EXT_BRK;
          else                       pstate_nxt = IDLE;
        end
        EXT_BRK: pstate_nxt = IDLE;
        default: pstate_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pstate <= IDLE;
    else        pstate <= pstate_nxt;
  end

  key_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev_vld    (ev_vld_p0),
    .ev_brk    (ev_brk_p0),
    .ev_code   (scan_code),
    .count     (held_count),
    .nxt_count (nxt_count),
    .nxt_top   (nxt_top)
  );

  // Outputs are computed from the post-event stack so they land on the same
  // edge as the stack update.
  assign top_note = note_lookup(nxt_top);

  always_comb begin
    freq_nxt = note_freq;
    gate_nxt = gate;
    tail_nxt = tail_cnt_p1;
    if (nxt_count != '0) begin
      freq_nxt = top_note.hit ? top_note.freq : '0;
      gate_nxt = 1'b1;
      tail_nxt = '0;
    end else if (held_count != '0) begin
      // Stack is emptying on this edge.
      if (TAIL_CYCLES == 0) begin
        freq_nxt = '0;
        gate_nxt = 1'b0;
        tail_nxt = '0;
      end else begin
        tail_nxt = TAIL_W'(1);
      end
    end else if (gate) begin
      // tail_cnt_p1 numbers the tail cycle currently being output.
      if (tail_cnt_p1 >= TAIL_C) begin
        freq_nxt = '0;
        gate_nxt = 1'b0;
        tail_nxt = '0;
      end else begin
        tail_nxt = tail_cnt_p1 + TAIL_W'(1);
      end
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_freq   <= '0;
      gate        <= 1'b0;
      note_change <= 1'b0;
      tail_cnt_p1 <= '0;
    end else begin
      note_freq   <= freq_nxt;
      gate        <= gate_nxt;
      note_change <= (freq_nxt != note_freq);
      tail_cnt_p1 <= tail_nxt;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Testbench for note_scheduler: two instances (no tail, 10-cycle tail) share
// one stimulus stream. A reference model predicts each cycle's outputs into a
// queue; a monitor pops and compares after every clock edge.
module tb_note_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        scan_valid = 1'b0;

  logic [11:0] freq0, freq1;
  logic        gate0, gate1, chg0, chg1;
  logic [3:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  note_scheduler #(.DEPTH(4), .TAIL_CYCLES(0), .TAIL_W(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .note_freq(freq0), .gate(gate0), .note_change(chg0), .held_count(cnt0));

  note_scheduler #(.DEPTH(4), .TAIL_CYCLES(10), .TAIL_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .note_freq(freq1), .gate(gate1), .note_change(chg1), .held_count(cnt1));

  typedef struct {
    int f0; int f1; int cnt;
    bit g0; bit g1; bit c0; bit c1;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------- reference model ----------------
  localparam int DEPTH = 4;
  int        tail_len[2] = '{0, 10};
  logic [7:0] stk[$];
  bit        pend_brk, pend_ext;
  int        mf[2];
  bit        mg[2];
  int        rem[2];

  function automatic int tone(logic [7:0] c);
    case (c)
      8'h1C: return 262;  8'h1B: return 294;
      8'h23: return 330;  8'h2B: return 349;
      8'h34: return 392;  8'h33: return 440;
      8'h3B: return 494;  8'h42: return 523;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    stk.delete();
    pend_brk = 0; pend_ext = 0;
    for (int j = 0; j < 2; j++) begin mf[j] = 0; mg[j] = 0; rem[j] = 0; end
  endtask

  task automatic model_press(logic [7:0] c);
    foreach (stk[i]) if (stk[i] == c) return;
    if (stk.size() == DEPTH) void'(stk.pop_front());
    stk.push_back(c);
  endtask

  task automatic model_release(logic [7:0] c);
    foreach (stk[i]) if (stk[i] == c) begin stk.delete(i); return; end
  endtask

  task automatic model_step(bit v, logic [7:0] c);
    exp_t e;
    int   old;
    bit   ch[2];
    if (v) begin
      if (c == 8'hF0 && !pend_brk) pend_brk = 1;
      else if (c == 8'hE0 && !pend_brk && !pend_ext) pend_ext = 1;
      else begin
        if (!pend_ext && tone(c) != 0) begin
          if (pend_brk) model_release(c);
          else          model_press(c);
        end
        pend_brk = 0; pend_ext = 0;
      end
    end
    for (int j = 0; j < 2; j++) begin
      old = mf[j];
      if (stk.size() > 0) begin
        mf[j] = tone(stk[stk.size()-1]); mg[j] = 1; rem[j] = tail_len[j];
      end else if (rem[j] > 0) begin
        rem[j]--;
      end else begin
        mf[j] = 0; mg[j] = 0;
      end
      ch[j] = (mf[j] != old);
    end
    e.f0 = mf[0]; e.g0 = mg[0]; e.c0 = ch[0];
    e.f1 = mf[1]; e.g1 = mg[1]; e.c1 = ch[1];
    e.cnt = stk.size();
    exp_q.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("freq0", int'(freq0), mon_e.f0);
      chk("gate0", int'(gate0), int'(mon_e.g0));
      chk("chg0",  int'(chg0),  int'(mon_e.c0));
      chk("cnt0",  int'(cnt0),  mon_e.cnt);
      chk("freq1", int'(freq1), mon_e.f1);
      chk("gate1", int'(gate1), int'(mon_e.g1));
      chk("chg1",  int'(chg1),  int'(mon_e.c1));
      chk("cnt1",  int'(cnt1),  mon_e.cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(bit v, logic [7:0] c);
    @(negedge clk);
    scan_valid = v;
    scan_code  = c;
    model_step(v, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    scan_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_freq0", int'(freq0), 0);
    chk("rst_gate1", int'(gate1), 0);
    chk("rst_chg0",  int'(chg0),  0);
    chk("rst_cnt0",  int'(cnt0),  0);
    chk("rst_freq1", int'(freq1), 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [7:0] keys[8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  logic [7:0] odd[3]  = '{8'h15, 8'h75, 8'h29};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    do_reset();

    // single press / release
    step(1, 8'h1C); settle();
    chk("press_freq", int'(freq0), 262);
    chk("press_gate", int'(gate0), 1);
    chk("press_chg",  int'(chg0), 1);
    chk("press_cnt",  int'(cnt0), 1);
    step(1, 8'hF0); step(1, 8'h1C); settle();
    chk("rel_freq", int'(freq0), 0);
    chk("rel_gate", int'(gate0), 0);
    chk("rel_chg",  int'(chg0), 1);
    chk("rel_cnt",  int'(cnt0), 0);

    // last-note priority
    step(1, 8'h1C); step(1, 8'h23); settle();
    chk("prio_freq", int'(freq0), 330);
    chk("prio_cnt",  int'(cnt0), 2);
    step(1, 8'hF0); step(1, 8'h23); settle();
    chk("prio_back", int'(freq0), 262);
    chk("prio_cnt1", int'(cnt0), 1);
    step(1, 8'hF0); step(1, 8'h1C);

    // typematic repeat
    repeat (5) step(1, 8'h1C);
    settle();
    chk("typ_cnt", int'(cnt0), 1);
    chk("typ_chg", int'(chg0), 0);
    step(1, 8'hF0); step(1, 8'h1C); settle();
    chk("typ_off", int'(freq0), 0);

    // overflow
    step(1, 8'h1C); step(1, 8'h1B); step(1, 8'h23); step(1, 8'h2B); step(1, 8'h34);
    settle();
    chk("ovf_freq", int'(freq0), 392);
    chk("ovf_cnt",  int'(cnt0), 4);
    step(1, 8'hF0); step(1, 8'h34); settle();
    chk("ovf_rel", int'(freq0), 349);
    step(1, 8'hF0); step(1, 8'h1C); settle();
    chk("ovf_drop_cnt",  int'(cnt0), 3);
    chk("ovf_drop_freq", int'(freq0), 349);
    step(1, 8'hF0); step(1, 8'h1B);
    step(1, 8'hF0); step(1, 8'h23);
    step(1, 8'hF0); step(1, 8'h2B);

    // prefixes and unmapped codes leave a held note alone
    step(1, 8'h33);
    step(1, 8'hE0); step(1, 8'h75);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75);
    step(1, 8'h15);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h33);
    settle();
    chk("pfx_freq", int'(freq0), 440);
    chk("pfx_cnt",  int'(cnt0), 1);
    chk("pfx_chg",  int'(chg0), 0);

    // pending break prefix cleared by reset
    step(1, 8'hF0);
    do_reset();
    step(1, 8'h1C); settle();
    chk("rstpfx_freq", int'(freq0), 262);
    chk("rstpfx_cnt",  int'(cnt0), 1);

    // release tail runs to completion
    do_reset();
    step(1, 8'h33); step(1, 8'hF0); step(1, 8'h33);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(0, 8'h00);
      settle();
      chk("tail_gate", int'(gate1), 1);
      chk("tail_freq", int'(freq1), 440);
      if (k == 0) chk("notail_freq", int'(freq0), 0);
    end
    step(0, 8'h00); settle();
    chk("tail_end_gate", int'(gate1), 0);
    chk("tail_end_freq", int'(freq1), 0);
    chk("tail_end_chg",  int'(chg1), 1);

    // make during tail cancels it
    step(1, 8'h33); step(1, 8'hF0); step(1, 8'h33);
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk("tail2_gate", int'(gate1), 1);
      chk("tail2_freq", int'(freq1), 440);
      if (k < 5) step(0, 8'h00);
      else       step(1, 8'h42);
    end
    settle();
    chk("tail2_new", int'(freq1), 523);
    chk("tail2_cnt", int'(cnt1), 1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      step(1, keys[$urandom_range(0, 7)]);
      else if (r < 72) step(1, 8'hF0);
      else if (r < 76) step(1, 8'hE0);
      else if (r < 80) step(1, odd[$urandom_range(0, 2)]);
      else             step(0, 8'h00);
      if ($urandom_range(0, 40) == 0) repeat (14) step(0, 8'h00);
      if (n == 1200) do_reset();
    end
    step(0, 8'h00);
    settle();
    @(posedge clk); #3;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
